// File: rtl/d5m_pkg.sv
// rtl/d5m_pkg.sv - shared state encoding and constants for the D5M configuration sequencer
package d5m_pkg;

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_RESP,
    ST_DONE,
    ST_UPD_ISSUE,
    ST_UPD_RESP,
    ST_ERROR
  } state_t;

  localparam logic [7:0] DEF_DEV_ADDR = 8'hBA;
  localparam logic [7:0] DEF_EXP_REG  = 8'h09;
  localparam logic [7:0] ERR_IDX_EXP  = 8'hFF;

  function automatic logic is_idle(state_t s);
    return (s == ST_DONE) || (s == ST_ERROR);
  endfunction

  // The table has completed once we are in DONE or servicing an exposure update.
  function automatic logic is_configured(state_t s);
    return (s == ST_DONE) || (s == ST_UPD_ISSUE) || (s == ST_UPD_RESP);
  endfunction

endpackage

// File: rtl/d5m_cfg_sequencer_if.sv
// rtl/d5m_cfg_sequencer_if.sv - command/response port between the sequencer and the byte-level I2C master
interface d5m_cfg_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_dev;
  logic [7:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ack;

  modport master (
    output cmd_valid, cmd_dev, cmd_reg, cmd_data,
    input  cmd_ready, rsp_valid, rsp_ack
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
    output cmd_ready, rsp_valid, rsp_ack
  );
endinterface

// File: rtl/d5m_cfg_rom.sv
// rtl/d5m_cfg_rom.sv - D5M register table, {reg[7:0], value[15:0]}, one-cycle read latency
module d5m_cfg_rom (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [23:0] data
);

  always_ff @(posedge clk) begin
    case (addr)
      8'd0:    data <= 24'h01_0036;
      8'd1:    data <= 24'h02_0010;
      8'd2:    data <= 24'h20_0011;
      8'd3:    data <= 24'h03_0797;
      8'd4:    data <= 24'h04_0A1F;
      8'd5:    data <= 24'h05_0000;
      8'd6:    data <= 24'h06_0019;
      8'd7:    data <= 24'h09_0797;
      8'd8:    data <= 24'h0A_8000;
      8'd9:    data <= 24'h10_0051;
      8'd10:   data <= 24'h11_1807;
      8'd11:   data <= 24'h12_0002;
      8'd12:   data <= 24'h10_0053;
      8'd13:   data <= 24'h1E_4006;
      8'd14:   data <= 24'h22_0000;
      8'd15:   data <= 24'h23_0000;
      8'd16:   data <= 24'h2B_000B;
      8'd17:   data <= 24'h2C_000F;
      8'd18:   data <= 24'h2D_000F;
      8'd19:   data <= 24'h2E_000B;
      8'd20:   data <= 24'h35_0018;
      8'd21:   data <= 24'h49_01A8;
      8'd22:   data <= 24'h0B_0001;
      8'd23:   data <= 24'h07_0002;
      default: data <= 24'h00_0000;
    endcase
  end

endmodule

// File: rtl/d5m_cfg_sequencer.sv
// rtl/d5m_cfg_sequencer.sv - walks the sensor register table over I2C after reset, then services exposure writes
module d5m_cfg_sequencer
  import d5m_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = DEF_DEV_ADDR,
  parameter int         TBL_LEN        = 24,
  parameter int         POWERUP_CYCLES = 50000,
  parameter int         MAX_RETRY      = 3,
  parameter logic [7:0] EXP_REG        = DEF_EXP_REG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       restart,
  output logic [7:0]                 tbl_addr,
  input  logic [23:0]                tbl_data,
  d5m_cfg_sequencer_if.master        cmd,
  input  logic                       exp_req,
  input  logic [15:0]                exp_value,
  output logic                       cfg_done,
  output logic                       cfg_error,
  output logic [7:0]                 err_index,
  output logic                       busy
);

  localparam int         RW       = $clog2(MAX_RETRY + 2);
  localparam logic [7:0] LAST_IDX = 8'(TBL_LEN - 1);
  localparam logic [19:0] PU_LAST = 20'(POWERUP_CYCLES - 1);

  state_t        state, state_n;
  logic [19:0]   wait_cnt, wait_cnt_n;
  logic [7:0]    idx, idx_n;
  logic [RW-1:0] retry, retry_n;
  logic          pend, pend_n;
  logic [15:0]   exp_hold, exp_hold_n;
  logic          valid_q, valid_n;
  logic [7:0]    dev_q;
  logic [7:0]    reg_q, reg_n;
  logic [15:0]   data_q, data_n;
  logic [7:0]    err_n;

  assign tbl_addr      = idx;
  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_dev   = dev_q;
  assign cmd.cmd_reg   = reg_q;
  assign cmd.cmd_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      wait_cnt  <= '0;
      idx       <= '0;
      retry     <= '0;
      pend      <= 1'b0;
      exp_hold  <= '0;
      valid_q   <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      err_index <= '0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      idx       <= idx_n;
      retry     <= retry_n;
      pend      <= pend_n;
      exp_hold  <= exp_hold_n;
      valid_q   <= valid_n;
      dev_q     <= DEV_ADDR;
      reg_q     <= reg_n;
      data_q    <= data_n;
      err_index <= err_n;
      cfg_done  <= is_configured(state_n);
      cfg_error <= (state_n == ST_ERROR);
      busy      <= !is_idle(state_n);
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    idx_n      = idx;
    retry_n    = retry;
    pend_n     = pend;
    exp_hold_n = exp_hold;
    valid_n    = valid_q;
    reg_n      = reg_q;
    data_n     = data_q;
    err_n      = err_index;

    if (exp_req && state != ST_ERROR) begin
      pend_n     = 1'b1;
      exp_hold_n = exp_value;
    end

    case (state)
      ST_WAIT: begin
        if (wait_cnt == PU_LAST) state_n = ST_FETCH;
        else                     wait_cnt_n = wait_cnt + 20'd1;
      end
      ST_FETCH: state_n = ST_LATCH;
      ST_LATCH: begin
        reg_n   = tbl_data[23:16];
        data_n  = tbl_data[15:0];
        valid_n = 1'b1;
        state_n = ST_ISSUE;
      end
      ST_ISSUE, ST_UPD_ISSUE: begin
        if (cmd.cmd_ready) begin
          valid_n = 1'b0;
          state_n = (state == ST_ISSUE) ? ST_RESP : ST_UPD_RESP;
        end
      end
      ST_RESP, ST_UPD_RESP: begin
        if (cmd.rsp_valid) begin
          if (cmd.rsp_ack) begin
            retry_n = '0;
            if (state == ST_UPD_RESP || idx == LAST_IDX) begin
              state_n = ST_DONE;
            end else begin
              idx_n   = idx + 8'd1;
              state_n = ST_FETCH;
            end
          end else if (retry != RW'(MAX_RETRY)) begin
            retry_n = retry + RW'(1);
            valid_n = 1'b1;
            state_n = (state == ST_RESP) ? ST_ISSUE : ST_UPD_ISSUE;
          end else begin
            err_n   = (state == ST_RESP) ? idx : ERR_IDX_EXP;
            state_n = ST_ERROR;
          end
        end
      end
      ST_DONE: begin
        if (restart) begin
          idx_n   = '0;
          retry_n = '0;
          err_n   = '0;
          state_n = ST_FETCH;
        end else if (pend || exp_req) begin
          // A fresh request is forwarded straight away; one landing on a consumed flag stays queued.
          reg_n   = EXP_REG;
          data_n  = pend ? exp_hold : exp_value;
          valid_n = 1'b1;
          pend_n  = pend && exp_req;
          state_n = ST_UPD_ISSUE;
        end
      end
      ST_ERROR: begin
        if (restart) begin
          idx_n   = '0;
          retry_n = '0;
          err_n   = '0;
          state_n = ST_FETCH;
        end
      end
      default: state_n = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_d5m_cfg_sequencer.sv
// tb/tb_d5m_cfg_sequencer.sv - directed bench for the D5M configuration sequencer with an I2C responder model
module tb_d5m_cfg_sequencer;

  localparam int TBL_LEN = 4;
  localparam int PU      = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        exp_req = 1'b0;
  logic [15:0] exp_value = 16'h0000;
  logic [7:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic        cfg_done, cfg_error, busy;
  logic [7:0]  err_index;

  always #5 clk = ~clk;

  d5m_cfg_sequencer_if cmd_if ();

  d5m_cfg_rom rom (.clk(clk), .addr(tbl_addr), .data(tbl_data));

  d5m_cfg_sequencer #(
    .DEV_ADDR(8'hBA), .TBL_LEN(TBL_LEN), .POWERUP_CYCLES(PU), .MAX_RETRY(3), .EXP_REG(8'h09)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd(cmd_if), .exp_req(exp_req), .exp_value(exp_value), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .err_index(err_index), .busy(busy)
  );

  logic [23:0] exp_tbl [4] = '{24'h01_0036, 24'h02_0010, 24'h20_0011, 24'h03_0797};

  int         stall_cycles = 0;
  int         nack_times = 0;
  logic [7:0] nack_reg = 8'h00;
  bit         stray_after_reset = 1'b0;
  logic [7:0]  log_reg[$];
  logic [7:0]  log_dev[$];
  logic [15:0] log_data[$];

  int n_checks = 0;
  int n_pass = 0;

  // Responder: stalls each command stall_cycles cycles, answers two cycles after acceptance.
  initial begin : i2c_model
    int stalled, rsp_pending, consec;
    bit prev_rst, last_nack, pend_ack, nack;
    logic [7:0] last_reg;
    stalled = 0; rsp_pending = 0; consec = 0;
    prev_rst = 1'b1; last_nack = 1'b0; pend_ack = 1'b1; last_reg = 8'h00;
    cmd_if.cmd_ready = 1'b1; cmd_if.rsp_valid = 1'b0; cmd_if.rsp_ack = 1'b0;
    forever begin
      @(negedge clk);
      cmd_if.rsp_valid = 1'b0;
      if (rsp_pending > 0) begin
        rsp_pending--;
        if (rsp_pending == 0) begin cmd_if.rsp_valid = 1'b1; cmd_if.rsp_ack = pend_ack; end
      end
      if (prev_rst && !rst && stray_after_reset) begin cmd_if.rsp_valid = 1'b1; cmd_if.rsp_ack = 1'b1; end
      prev_rst = rst;
      if (rst) rsp_pending = 0;
      if (cmd_if.cmd_valid && !rst) begin
        if (stalled < stall_cycles) begin
          cmd_if.cmd_ready = 1'b0;
          stalled++;
        end else begin
          cmd_if.cmd_ready = 1'b1;
          stalled = 0;
          log_reg.push_back(cmd_if.cmd_reg);
          log_dev.push_back(cmd_if.cmd_dev);
          log_data.push_back(cmd_if.cmd_data);
          if (cmd_if.cmd_reg == last_reg && last_nack) consec++;
          else consec = 0;
          nack = (cmd_if.cmd_reg == nack_reg) && (consec < nack_times);
          last_reg = cmd_if.cmd_reg;
          last_nack = nack;
          pend_ack = !nack;
          rsp_pending = 2;
        end
      end else begin
        cmd_if.cmd_ready = 1'b1;
      end
    end
  end

  task automatic pulse_restart;
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic wait_idle(output bit timeout);
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    timeout = busy;
  endtask

  task automatic wait_valid(output bit found);
    int n;
    n = 0;
    while (!cmd_if.cmd_valid && n < 200) begin @(negedge clk); n++; end
    found = cmd_if.cmd_valid;
  endtask

  task automatic release_and_time(output int lat);
    @(negedge clk); rst = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!cmd_if.cmd_valid && lat < 200);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if ({cmd_if.cmd_valid, cfg_done, cfg_error, busy} !== 4'b0001)
      $display("FAIL reset_flags: got %b expected 0001", {cmd_if.cmd_valid, cfg_done, cfg_error, busy}); else n_pass++;
    n_checks++; if ({cmd_if.cmd_dev, cmd_if.cmd_reg, cmd_if.cmd_data} !== 32'h0)
      $display("FAIL reset_payload: got %h expected 00000000", {cmd_if.cmd_dev, cmd_if.cmd_reg, cmd_if.cmd_data}); else n_pass++;
    n_checks++; if ({tbl_addr, err_index} !== 16'h0)
      $display("FAIL reset_addr_err: got %h expected 0000", {tbl_addr, err_index}); else n_pass++;
  endtask

  task automatic test_basic_walk;
    int lat, base;
    bit to;
    base = log_reg.size();
    release_and_time(lat);
    n_checks++; if (lat !== 12) $display("FAIL first_cmd_latency: got %0d expected 12", lat); else n_pass++;
    wait_idle(to);
    n_checks++; if (to !== 1'b0) $display("FAIL walk_timeout: busy stuck expected idle"); else n_pass++;
    n_checks++; if (log_reg.size() - base !== 4) $display("FAIL walk_count: got %0d expected 4", log_reg.size() - base); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (base + i >= log_reg.size() || {log_dev[base+i], log_reg[base+i], log_data[base+i]} !== {8'hBA, exp_tbl[i]})
        $display("FAIL walk_entry%0d: got missing-or-wrong expected %h", i, {8'hBA, exp_tbl[i]});
      else n_pass++;
    end
    n_checks++; if ({cfg_done, busy, cfg_error} !== 3'b100)
      $display("FAIL walk_done_flags: got %b expected 100", {cfg_done, busy, cfg_error}); else n_pass++;
  endtask

  task automatic test_backpressure;
    int base, n01;
    bit found, to;
    stall_cycles = 7;
    base = log_reg.size();
    pulse_restart();
    wait_valid(found);
    n_checks++; if (found !== 1'b1) $display("FAIL bp_valid_seen: got 0 expected 1"); else n_pass++;
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if ({cmd_if.cmd_valid, cmd_if.cmd_reg, cmd_if.cmd_data} !== {1'b1, 8'h01, 16'h0036})
        $display("FAIL bp_stable_cycle%0d: got %h expected 1010036", k, {cmd_if.cmd_valid, cmd_if.cmd_reg, cmd_if.cmd_data});
      else n_pass++;
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++; if (cmd_if.cmd_valid !== 1'b0) $display("FAIL bp_accept_drop: got %b expected 0", cmd_if.cmd_valid); else n_pass++;
    wait_idle(to);
    stall_cycles = 0;
    n01 = 0;
    for (int i = base; i < log_reg.size(); i++) if (log_reg[i] == 8'h01) n01++;
    n_checks++; if (n01 !== 1) $display("FAIL bp_single_accept: got %0d expected 1", n01); else n_pass++;
    n_checks++; if ({to, cfg_done, log_reg.size() - base} !== {1'b0, 1'b1, 32'd4})
      $display("FAIL bp_walk_complete: got to=%b done=%b n=%0d expected 0 1 4", to, cfg_done, log_reg.size() - base); else n_pass++;
  endtask

  task automatic test_nack_retry;
    int base;
    bit to;
    nack_reg = 8'h02; nack_times = 2;
    base = log_reg.size();
    pulse_restart();
    wait_idle(to);
    nack_times = 0;
    n_checks++; if ({to, log_reg.size() - base} !== {1'b0, 32'd6})
      $display("FAIL nack_count: got to=%b n=%0d expected 0 6", to, log_reg.size() - base); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (base + i >= log_reg.size() || {log_reg[base+i], log_data[base+i]} !== 24'h02_0010)
        $display("FAIL nack_repeat%0d: got missing-or-wrong expected 020010", i);
      else n_pass++;
    end
    n_checks++; if ({cfg_done, cfg_error} !== 2'b10)
      $display("FAIL nack_final_flags: got %b expected 10", {cfg_done, cfg_error}); else n_pass++;
  endtask

  task automatic test_retry_exhaust;
    int base, n20;
    bit to;
    nack_reg = 8'h20; nack_times = 1000;
    base = log_reg.size();
    pulse_restart();
    wait_idle(to);
    n_checks++; if ({to, cfg_done, cfg_error, busy} !== 4'b0010)
      $display("FAIL exhaust_flags: got %b expected 0010", {to, cfg_done, cfg_error, busy}); else n_pass++;
    n_checks++; if (err_index !== 8'd2) $display("FAIL exhaust_err_index: got %0d expected 2", err_index); else n_pass++;
    n20 = 0;
    for (int i = base; i < log_reg.size(); i++) if (log_reg[i] == 8'h20) n20++;
    n_checks++; if (n20 !== 4) $display("FAIL exhaust_attempts: got %0d expected 4", n20); else n_pass++;
    nack_times = 0;
    base = log_reg.size();
    pulse_restart();
    n_checks++; if ({cfg_error, busy, err_index} !== {1'b0, 1'b1, 8'h00})
      $display("FAIL restart_clears: got err=%b busy=%b idx=%h expected 0 1 00", cfg_error, busy, err_index); else n_pass++;
    wait_idle(to);
    n_checks++; if (log_reg.size() <= base || log_reg[base] !== 8'h01)
      $display("FAIL restart_from_zero: got missing-or-wrong expected first reg 01"); else n_pass++;
    n_checks++; if ({to, cfg_done, cfg_error, log_reg.size() - base} !== {3'b010, 32'd4})
      $display("FAIL restart_complete: got to=%b done=%b err=%b n=%0d expected 0 1 0 4", to, cfg_done, cfg_error, log_reg.size() - base); else n_pass++;
  endtask

  task automatic test_exposure;
    int base, n09;
    bit to;
    base = log_reg.size();
    pulse_restart();
    @(negedge clk); exp_req = 1'b1; exp_value = 16'h0400;
    @(negedge clk); exp_req = 1'b0;
    repeat (4) @(negedge clk);
    exp_req = 1'b1; exp_value = 16'h0600;
    @(negedge clk); exp_req = 1'b0;
    wait_idle(to);
    repeat (12) @(negedge clk);
    wait_idle(to);
    n09 = 0;
    for (int i = base; i < log_reg.size(); i++) if (log_reg[i] == 8'h09) n09++;
    n_checks++; if ({n09, log_reg.size() - base} !== {32'd1, 32'd5})
      $display("FAIL exp_single_cmd: got n09=%0d n=%0d expected 1 5", n09, log_reg.size() - base); else n_pass++;
    n_checks++; if ({log_reg[log_reg.size()-1], log_data[log_data.size()-1]} !== 24'h09_0600)
      $display("FAIL exp_latest_value: got %h expected 090600", {log_reg[log_reg.size()-1], log_data[log_data.size()-1]}); else n_pass++;
    n_checks++; if ({to, cfg_done, busy} !== 3'b010)
      $display("FAIL exp_idle_flags: got %b expected 010", {to, cfg_done, busy}); else n_pass++;
    base = log_reg.size();
    @(negedge clk); exp_req = 1'b1; exp_value = 16'h0800;
    @(negedge clk); exp_req = 1'b0;
    n_checks++; if ({cmd_if.cmd_valid, cmd_if.cmd_reg, cmd_if.cmd_data, cfg_done} !== {1'b1, 24'h09_0800, 1'b1})
      $display("FAIL exp_done_latency: got %h expected 1090801", {cmd_if.cmd_valid, cmd_if.cmd_reg, cmd_if.cmd_data, cfg_done}); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (log_reg.size() - base !== 1 || log_data[log_data.size()-1] !== 16'h0800)
      $display("FAIL exp_done_issued: got n=%0d expected 1 write of 0800", log_reg.size() - base); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int base, lat;
    bit found, to;
    stall_cycles = 1000;
    base = log_reg.size();
    pulse_restart();
    wait_valid(found);
    n_checks++; if (found !== 1'b1) $display("FAIL rstmid_issue_seen: got 0 expected 1"); else n_pass++;
    stray_after_reset = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({cmd_if.cmd_valid, busy, cfg_done} !== 3'b010)
      $display("FAIL rstmid_valid_drop: got %b expected 010", {cmd_if.cmd_valid, busy, cfg_done}); else n_pass++;
    stall_cycles = 0;
    repeat (2) @(negedge clk);
    release_and_time(lat);
    n_checks++; if (lat !== 12) $display("FAIL rstmid_powerup_wait: got %0d expected 12", lat); else n_pass++;
    wait_idle(to);
    stray_after_reset = 1'b0;
    n_checks++; if (log_reg.size() - base !== 4 || log_reg[base] !== 8'h01)
      $display("FAIL rstmid_rewalk: got n=%0d expected 4 starting at reg 01", log_reg.size() - base); else n_pass++;
    n_checks++; if ({to, cfg_done, cfg_error} !== 3'b010)
      $display("FAIL rstmid_final_flags: got %b expected 010", {to, cfg_done, cfg_error}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_walk();
    test_backpressure();
    test_nack_retry();
    test_retry_exhaust();
    test_exposure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1);
  end

endmodule

// File: doc/d5m_cfg_sequencer.md
Name: d5m_cfg_sequencer

Overview:
- Sequences the D5M sensor's I2C register configuration after reset.
- Walks an external register table of (register address, 16-bit value) entries. Issues one write per entry to a byte-level I2C master through a valid/ready command port and checks the ACK response of each write.
- After the table completes, services runtime exposure updates.
- Sits between the sensor reset/power-up logic and the I2C master that drives sclk/sdata.

Parameters:
- DEV_ADDR, 8'hBA: 8-bit I2C write address of the sensor.
- TBL_LEN, 24: number of table entries; range 1..256.
- POWERUP_CYCLES, 50000: clk cycles to wait after reset before the first command; range 1..2^20-1.
- MAX_RETRY, 3: retries per entry after a NACK before declaring an error.
- EXP_REG, 8'h09: register address used for exposure updates.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- restart  in  1  pulse; re-runs the table from index 0; honoured only in ST_DONE or ST_ERROR
- tbl_addr  out  8  table read index
- tbl_data  in  24  [23:16] register address, [15:0] value; valid exactly 1 cycle after tbl_addr changes
- cmd_valid  out  1  command valid to the I2C master
- cmd_ready  in  1  I2C master accepts the command
- cmd_dev  out  8  device address
- cmd_reg  out  8  register address
- cmd_data  out  16  register value
- rsp_valid  in  1  one-cycle pulse; write transaction finished
- rsp_ack  in  1  qualified by rsp_valid; 1 = ACK, 0 = NACK
- exp_req  in  1  pulse; request an exposure write
- exp_value  in  16  exposure value, sampled when exp_req=1
- cfg_done  out  1  table completed with no error
- cfg_error  out  1  retries exhausted; sticky
- err_index  out  8  table index that failed (8'hFF if the exposure write failed)
- busy  out  1  state is neither ST_DONE nor ST_ERROR

Behaviour:
- Reset: one clock domain. Reset is synchronous, active-high (rst), applied on the posedge of clk.
  - On reset: state=ST_WAIT; tbl_addr=0; cmd_valid=0; cmd_dev/cmd_reg/cmd_data=0; cfg_done=0; cfg_error=0; err_index=0; busy=1.
  - Internal counters and the pending-exposure flag clear.
  - Reset asserted mid-transaction drops cmd_valid on the next edge. Any later rsp_valid is ignored until ST_RESP is reached again.
- All outputs are registered. cmd_dev always equals DEV_ADDR outside reset.
- States and transitions:
  - ST_WAIT: count to POWERUP_CYCLES-1, then go to ST_FETCH.
  - ST_FETCH: tbl_addr=idx; go to ST_LATCH.
  - ST_LATCH: cmd_reg←tbl_data[23:16]; cmd_data←tbl_data[15:0]; cmd_valid←1; go to ST_ISSUE.
  - ST_ISSUE: hold cmd_valid and the payload stable until cmd_ready=1. On that edge: cmd_valid←0, go to ST_RESP.
  - ST_RESP: wait for rsp_valid.
    - ACK: retry count←0. If idx==TBL_LEN-1 go to ST_DONE; otherwise idx+1 and go to ST_FETCH.
    - NACK with retry count<MAX_RETRY: retry count+1; re-assert cmd_valid with the same payload; go to ST_ISSUE.
    - NACK with retry count==MAX_RETRY: err_index←idx; go to ST_ERROR.
  - ST_DONE: cfg_done=1.
    - If an exposure write is pending: cmd_reg←EXP_REG, cmd_data←held value, cmd_valid←1, clear the pending flag, go to ST_UPD_ISSUE.
  - ST_UPD_ISSUE / ST_UPD_RESP: same handshake and retry rules as ST_ISSUE / ST_RESP.
    - ACK returns to ST_DONE.
    - Exhausted retries: err_index←8'hFF, go to ST_ERROR.
    - cfg_done stays 1 during the update.
  - ST_ERROR: cfg_error=1, cfg_done=0, cmd_valid=0.
- Latency: ACK of entry k to cmd_valid for entry k+1 is 3 cycles (RESP→FETCH→LATCH→ISSUE).
- Exposure requests:
  - exp_req is accepted in every state except ST_ERROR. It sets the pending flag and captures exp_value; the latest request overwrites any earlier un-issued value.
  - A request during ST_WAIT or the table walk is serviced on the first ST_DONE cycle.
  - A request arriving in the same cycle the flag is consumed stays pending and is issued after the current update.
- restart:
  - In ST_DONE or ST_ERROR: clears cfg_done, cfg_error, err_index, idx and retry count; goes to ST_FETCH. There is no power-up wait.
  - Ignored in all other states.
  - restart and a pending exposure in the same ST_DONE cycle: restart wins and the exposure stays pending.
- rsp_valid outside ST_RESP / ST_UPD_RESP is ignored.

Decomposition:
- d5m_pkg holds:
  - state encoding (ST_WAIT, ST_FETCH, ST_LATCH, ST_ISSUE, ST_RESP, ST_DONE, ST_UPD_ISSUE, ST_UPD_RESP, ST_ERROR);
  - default constants DEV_ADDR 8'hBA and EXP_REG 8'h09;
  - the error index sentinel 8'hFF.
- One sub-module, d5m_cfg_rom: synchronous 24-bit table ROM with 1-cycle latency. It is instantiated beside the sequencer, not inside it.

Test Plan:
- Basic walk: TBL_LEN=4, POWERUP_CYCLES=10, I2C model always ACKs.
  - First cmd_valid appears 12 cycles after rst deasserts.
  - Exactly 4 commands, each carrying cmd_dev=8'hBA and the table contents (e.g. entry 2 = 24'h20_0011 → cmd_reg 8'h20, cmd_data 16'h0011).
  - cfg_done rises and busy falls after the 4th ACK.
- Backpressure: cmd_ready held low 7 cycles → cmd_valid and payload stable for all 7 cycles; exactly one command is accepted.
- NACK then ACK: entry 1 NACKed twice, then ACKed → 3 identical commands for entry 1; cfg_error stays 0; the walk completes.
- Retry exhaustion: MAX_RETRY=3, entry 2 always NACKs → 4 attempts, then cfg_error=1, err_index=2, cfg_done=0. A following restart re-runs from index 0 and clears the error.
- Exposure updates:
  - exp_req with 16'h0400 during the walk, then again with 16'h0600 before ST_DONE → after completion, a single command with cmd_reg 8'h09 and cmd_data 16'h0600.
  - exp_req with 16'h0800 in ST_DONE → cmd_valid for that command appears 1 cycle later.
- Reset mid-operation: assert rst while in ST_ISSUE → cmd_valid=0 on the next edge; a stray rsp_valid is ignored; the sequence restarts with the full power-up wait.
